rgb2hsv_converter: RTL and testbench

- Upstream stage of hsv2color_coding: converts one 24-bit RGB facelet sample to the packed 25-bit HSV word {H[8:0], S[7:0], V[7:0]} that the colour classifier consumes.
- Same enable/done pulse handshake as the classifier.
- Uses one shared sequential restoring divider, so latency is fixed and no combinational dividers are needed.

---
 rtl/hsv_pkg.sv | 46 ++++
 rtl/seq_divider.sv | 60 ++++++
 rtl/rgb2hsv_converter.sv | 185 ++++++++++++++++++
 tb/tb_rgb2hsv_converter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/hsv_pkg.sv
// Shared RGB/HSV field layout, hue constants and converter state encodings.
// Imported by the RGB->HSV converter and by the downstream colour classifier.
package hsv_pkg;

  localparam int CH_W   = 8;
  localparam int H_W    = 9;
  localparam int RGB_W  = 3 * CH_W;
  localparam int HSV_W  = H_W + 2 * CH_W;

  localparam int R_LSB  = 16;
  localparam int G_LSB  = 8;
  localparam int B_LSB  = 0;
  localparam int H_LSB  = 16;
  localparam int S_LSB  = 8;
  localparam int V_LSB  = 0;

  localparam int HUE_SECTOR = 60;
  localparam int HUE_G_BASE = 120;
  localparam int HUE_B_BASE = 240;
  localparam int HUE_FULL   = 360;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MINMAX,
    S_DIV_S,
    S_DIV_H,
    S_PACK,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    MAX_R,
    MAX_G,
    MAX_B
  } max_sel_t;

  // Negative hue clamps to 0; a full turn (only 360 is reachable) wraps to 0.
  function automatic logic [H_W-1:0] hue_wrap(input logic signed [9:0] h);
    logic signed [9:0] t;
    t = h;
    if (h < 10'sd0) t = 10'sd0;
    else if (h >= $signed(10'(HUE_FULL))) t = h - $signed(10'(HUE_FULL));
    return t[H_W-1:0];
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one load cycle on start, then DIV_W iteration cycles.
// done pulses for one cycle once quotient is final; divisor 0 yields all-ones.
module seq_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic             done
);

  localparam int CNT_W = $clog2(DIV_W + 1);

  logic [DIV_W-1:0] r_rem;
  logic [DIV_W-1:0] r_quo;
  logic [DIV_W-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [DIV_W:0]   w_shift;
  logic [DIV_W:0]   w_trial;

  // Dividend bits shift out of the quotient register as quotient bits shift in.
  assign w_shift = {r_rem, r_quo[DIV_W-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvs  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_rem <= '0;
        r_quo <= dividend;
        r_dvs <= divisor;
        r_cnt <= CNT_W'(DIV_W);
      end else if (r_cnt != '0) begin
        r_cnt  <= r_cnt - 1'b1;
        r_done <= (r_cnt == CNT_W'(1));
        if (!w_trial[DIV_W]) begin
          r_rem <= w_trial[DIV_W-1:0];
          r_quo <= {r_quo[DIV_W-2:0], 1'b1};
        end else begin
          r_rem <= w_shift[DIV_W-1:0];
          r_quo <= {r_quo[DIV_W-2:0], 1'b0};
        end
      end
    end
  end

  assign quotient = r_quo;
  assign done     = r_done;

endmodule

// File: rtl/rgb2hsv_converter.sv
// Converts one RGB sample to packed {H,S,V} using one shared sequential divider.
// Fixed latency of 2*DIV_W+4 cycles from accepted enable to the done pulse.
module rgb2hsv_converter
  import hsv_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [RGB_W-1:0] rgb24,
  output logic [HSV_W-1:0] hsv25,
  output logic             busy,
  output logic             done
);

  if (DIV_W < 16) begin : g_bad_div_w
    $error("DIV_W must be at least 16");
  end

  state_t           r_state;
  state_t           w_state_nxt;

  logic [RGB_W-1:0] r_rgb;
  logic [CH_W-1:0]  r_max;
  logic [CH_W-1:0]  r_delta;
  logic [CH_W-1:0]  r_absdiff;
  logic [CH_W-1:0]  r_s;
  logic             r_neg;
  max_sel_t         r_sel;
  logic [6:0]       r_q_h;
  logic [HSV_W-1:0] r_hsv;

  logic [CH_W-1:0]  w_r;
  logic [CH_W-1:0]  w_g;
  logic [CH_W-1:0]  w_b;
  logic [CH_W-1:0]  w_max;
  logic [CH_W-1:0]  w_min;
  logic [CH_W-1:0]  w_delta;
  logic [CH_W-1:0]  w_absdiff;
  logic             w_neg;
  max_sel_t         w_sel;

  logic [15:0]      w_prod_s;
  logic [15:0]      w_prod_h;
  logic             w_div_start;
  logic             w_div_done;
  logic [DIV_W-1:0] w_div_dvd;
  logic [DIV_W-1:0] w_div_dvs;
  logic [DIV_W-1:0] w_div_quo;

  logic signed [9:0] w_base;
  logic signed [9:0] w_q10;
  logic signed [9:0] w_hue_raw;
  logic [H_W-1:0]    w_hue;

  assign w_r = r_rgb[R_LSB +: CH_W];
  assign w_g = r_rgb[G_LSB +: CH_W];
  assign w_b = r_rgb[B_LSB +: CH_W];

  // Max channel with R > G > B tie priority; diff sign/magnitude follow that channel.
  always_comb begin
    w_sel     = MAX_B;
    w_max     = w_b;
    w_neg     = (w_r < w_g);
    w_absdiff = w_neg ? (w_g - w_r) : (w_r - w_g);
    if (w_r >= w_g && w_r >= w_b) begin
      w_sel     = MAX_R;
      w_max     = w_r;
      w_neg     = (w_g < w_b);
      w_absdiff = w_neg ? (w_b - w_g) : (w_g - w_b);
    end else if (w_g >= w_b) begin
      w_sel     = MAX_G;
      w_max     = w_g;
      w_neg     = (w_b < w_r);
      w_absdiff = w_neg ? (w_r - w_b) : (w_b - w_r);
    end
    w_min = (w_r < w_g) ? w_r : w_g;
    if (w_b < w_min) w_min = w_b;
    w_delta = w_max - w_min;
  end

  assign w_prod_s = {8'b0, w_delta} * 16'd255;
  assign w_prod_h = {8'b0, r_absdiff} * 16'(HUE_SECTOR);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // The S division is launched from S_MINMAX and the H division on the S result,
  // so neither start costs a separate state.
  always_comb begin
    w_state_nxt = r_state;
    w_div_start = 1'b0;
    w_div_dvd   = DIV_W'(w_prod_s);
    w_div_dvs   = DIV_W'(w_max);
    case (r_state)
      S_IDLE:   if (enable) w_state_nxt = S_MINMAX;
      S_MINMAX: begin
        w_div_start = 1'b1;
        w_state_nxt = S_DIV_S;
      end
      S_DIV_S:  if (w_div_done) begin
        w_div_start = 1'b1;
        w_div_dvd   = DIV_W'(w_prod_h);
        w_div_dvs   = DIV_W'(r_delta);
        w_state_nxt = S_DIV_H;
      end
      S_DIV_H:  if (w_div_done) w_state_nxt = S_PACK;
      S_PACK:   w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  seq_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (w_div_start),
    .dividend (w_div_dvd),
    .divisor  (w_div_dvs),
    .quotient (w_div_quo),
    .done     (w_div_done)
  );

  always_comb begin
    w_q10 = $signed({3'b000, r_q_h});
    case (r_sel)
      MAX_R:   w_base = r_neg ? $signed(10'(HUE_FULL)) : 10'sd0;
      MAX_G:   w_base = $signed(10'(HUE_G_BASE));
      default: w_base = $signed(10'(HUE_B_BASE));
    endcase
    w_hue_raw = r_neg ? (w_base - w_q10) : (w_base + w_q10);
    w_hue     = (r_delta == '0) ? '0 : hue_wrap(w_hue_raw);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb     <= '0;
      r_max     <= '0;
      r_delta   <= '0;
      r_absdiff <= '0;
      r_neg     <= 1'b0;
      r_sel     <= MAX_R;
      r_s       <= '0;
      r_q_h     <= '0;
      r_hsv     <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (enable) r_rgb <= rgb24;
        S_MINMAX: begin
          r_max     <= w_max;
          r_delta   <= w_delta;
          r_absdiff <= w_absdiff;
          r_neg     <= w_neg;
          r_sel     <= w_sel;
        end
        S_DIV_S: if (w_div_done) begin
          // max=0 divides by zero; the all-ones quotient is discarded.
          if (r_max == '0)                         r_s <= '0;
          else if (|w_div_quo[DIV_W-1:CH_W])       r_s <= '1;
          else                                     r_s <= w_div_quo[CH_W-1:0];
        end
        S_DIV_H: if (w_div_done) begin
          if (r_delta == '0 || (|w_div_quo[DIV_W-1:7])) r_q_h <= '0;
          else                                         r_q_h <= w_div_quo[6:0];
        end
        S_PACK: begin
          r_hsv[H_LSB +: H_W]  <= w_hue;
          r_hsv[S_LSB +: CH_W] <= r_s;
          r_hsv[V_LSB +: CH_W] <= r_max;
        end
        default: ;
      endcase
    end
  end

  assign hsv25 = r_hsv;
  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE);

endmodule

// File: tb/tb_rgb2hsv_converter.sv
// Directed-vector bench for rgb2hsv_converter: values, latency, busy window,
// ignored mid-conversion enable and synchronous reset abort.
module tb_rgb2hsv_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [23:0] rgb24;
  logic [24:0] hsv25;
  logic        busy;
  logic        done;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  rgb2hsv_converter #(
    .DIV_W (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .rgb24  (rgb24),
    .hsv25  (hsv25),
    .busy   (busy),
    .done   (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [24:0] pk(input int h, input int s, input int v);
    return {9'(h), 8'(s), 8'(v)};
  endfunction

  // One conversion; inject_at > 0 pulses a second enable at that cycle of busy.
  task automatic run_conv(input string tag, input logic [23:0] rgb,
                          input logic [24:0] exp, input int inject_at);
    int cyc;
    int bcnt;
    @(negedge clk);
    enable = 1'b1;
    rgb24  = rgb;
    @(posedge clk);
    #1;
    enable = 1'b0;
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    cyc  = 0;
    bcnt = 0;
    while (cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      enable = 1'b0;
      if (done) break;
      if (busy) bcnt++;
      if (cyc == inject_at) begin
        enable = 1'b1;
        rgb24  = 24'hFFFFFF;
      end
    end
    chk({tag, "_latency"}, 32'(cyc), 32'd36);
    chk({tag, "_busy_cycles"}, 32'(bcnt), 32'd35);
    chk({tag, "_hsv"}, 32'(hsv25), 32'(exp));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_done_fall"}, 32'(done), 32'd0);
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, 32'(hsv25), 32'(exp));
  endtask

  logic [23:0] vec_rgb [13];
  logic [24:0] vec_exp [13];

  initial begin
    int nd;

    vec_rgb[0]  = 24'hFF0000; vec_exp[0]  = pk(0,   255, 255);
    vec_rgb[1]  = 24'hFFFF00; vec_exp[1]  = pk(60,  255, 255);
    vec_rgb[2]  = 24'hFF8000; vec_exp[2]  = pk(30,  255, 255);
    vec_rgb[3]  = 24'h00FF00; vec_exp[3]  = pk(120, 255, 255);
    vec_rgb[4]  = 24'h0000FF; vec_exp[4]  = pk(240, 255, 255);
    vec_rgb[5]  = 24'hFF0080; vec_exp[5]  = pk(330, 255, 255);
    vec_rgb[6]  = 24'hFFFFFF; vec_exp[6]  = pk(0,   0,   255);
    vec_rgb[7]  = 24'h000000; vec_exp[7]  = pk(0,   0,   0);
    vec_rgb[8]  = 24'hC86464; vec_exp[8]  = pk(0,   127, 200);
    vec_rgb[9]  = 24'h00FFFF; vec_exp[9]  = pk(180, 255, 255);
    vec_rgb[10] = 24'h8000FF; vec_exp[10] = pk(270, 255, 255);
    vec_rgb[11] = 24'h80FF00; vec_exp[11] = pk(90,  255, 255);
    vec_rgb[12] = 24'hFF0001; vec_exp[12] = pk(0,   255, 255);

    rst    = 1'b1;
    enable = 1'b0;
    rgb24  = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hsv",  32'(hsv25), 32'd0);
    chk("reset_busy", 32'(busy),  32'd0);
    chk("reset_done", 32'(done),  32'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_conv($sformatf("vec%0d", i), vec_rgb[i], vec_exp[i], 0);
    end

    // Enable during busy must neither restart nor queue a conversion.
    run_conv("ignore", 24'h0000FF, pk(240, 255, 255), 10);
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    chk("ignore_no_extra_done", 32'(nd), 32'd0);

    // Reset sampled on cycle 10 of a conversion aborts it.
    @(negedge clk);
    enable = 1'b1;
    rgb24  = 24'hFF0000;
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_done", 32'(done),  32'd0);
    chk("abort_busy", 32'(busy),  32'd0);
    chk("abort_hsv",  32'(hsv25), 32'd0);
    nd = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) nd++;
    end
    chk("abort_quiet", 32'(nd), 32'd0);

    run_conv("after_abort", 24'hFF8000, pk(30, 255, 255), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
